// File: rtl/dram_app_model.sv
// Behavioural MIG app-interface responder: queued line commands, in-order fixed-latency reads.
// Define DRAM_REFRESH_EN to add periodic 8-cycle refresh windows every 512 calibrated cycles.
module dram_app_model #(
   parameter int unsigned APP_ADDR_WIDTH = 28,
   parameter int unsigned APP_CMD_WIDTH  = 3,
   parameter int unsigned APP_DATA_WIDTH = 128,
   parameter int unsigned APP_MASK_WIDTH = 16,
   parameter int unsigned MEM_LINES      = 4096,
   parameter int unsigned RD_LATENCY     = 8,
   parameter int unsigned QUEUE_DEPTH    = 4,
   parameter int unsigned INIT_CYCLES    = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst_x,
   output logic                      o_init_calib_complete,
   input  logic [APP_ADDR_WIDTH-1:0] i_app_addr,
   input  logic [APP_CMD_WIDTH-1:0]  i_app_cmd,
   input  logic                      i_app_en,
   output logic                      o_app_rdy,
   input  logic [APP_DATA_WIDTH-1:0] i_app_wdf_data,
   input  logic [APP_MASK_WIDTH-1:0] i_app_wdf_mask,
   input  logic                      i_app_wdf_wren,
   input  logic                      i_app_wdf_end,
   output logic                      o_app_wdf_rdy,
   output logic [APP_DATA_WIDTH-1:0] o_app_rd_data,
   output logic                      o_app_rd_data_valid,
   output logic                      o_app_rd_data_end
);

   localparam int unsigned PW = $clog2(QUEUE_DEPTH);
   localparam int unsigned LW = $clog2(MEM_LINES);
   localparam int unsigned IW = $clog2(INIT_CYCLES + 1);
   localparam logic [APP_CMD_WIDTH-1:0] CMD_WR = '0;
   localparam logic [APP_CMD_WIDTH-1:0] CMD_RD = APP_CMD_WIDTH'(1);
   localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

   logic [IW-1:0] init_cnt;
   logic          calib;
   logic          refresh;

   always_ff @(posedge i_clk) begin
      if (!i_rst_x) begin
         init_cnt <= '0;
         calib    <= 1'b0;
      end else if (!calib) begin
         if (init_cnt == IW'(INIT_CYCLES - 1)) calib <= 1'b1;
         else init_cnt <= init_cnt + IW'(1);
      end
   end

`ifdef DRAM_REFRESH_EN
   logic [8:0] ref_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_x) ref_cnt <= '0;
      else if (calib) ref_cnt <= ref_cnt + 9'd1;
   end

   // Last 8 cycles of every 512-cycle period after calibration.
   assign refresh = calib && (ref_cnt >= 9'd504);
`else
   assign refresh = 1'b0;
`endif

   // Command queue and write-data FIFO, pointers carry an extra wrap bit.
   logic [APP_CMD_WIDTH-1:0]  cq_cmd  [QUEUE_DEPTH];
   logic [LW-1:0]             cq_line [QUEUE_DEPTH];
   logic [APP_DATA_WIDTH-1:0] wf_data [QUEUE_DEPTH];
   logic [APP_MASK_WIDTH-1:0] wf_mask [QUEUE_DEPTH];
   logic [PW:0]               cq_wp, cq_rp, wf_wp, wf_rp;
   logic                      cq_empty, cq_full, wf_empty, wf_full;
   logic                      cq_push, wf_push;

   assign cq_empty = (cq_wp == cq_rp);
   assign cq_full  = (cq_wp[PW] != cq_rp[PW]) && (cq_wp[PW-1:0] == cq_rp[PW-1:0]);
   assign wf_empty = (wf_wp == wf_rp);
   assign wf_full  = (wf_wp[PW] != wf_rp[PW]) && (wf_wp[PW-1:0] == wf_rp[PW-1:0]);

   assign o_init_calib_complete = calib;
   assign o_app_rdy     = calib && !cq_full && !refresh;
   assign o_app_wdf_rdy = calib && !wf_full;
   assign cq_push = i_app_en && o_app_rdy;
   assign wf_push = i_app_wdf_wren && o_app_wdf_rdy;

   logic [APP_DATA_WIDTH-1:0] mem [MEM_LINES];
   logic [APP_CMD_WIDTH-1:0]  head_cmd;
   logic [LW-1:0]             head_line;
   logic [APP_DATA_WIDTH-1:0] head_wdata;
   logic [APP_MASK_WIDTH-1:0] head_wmask;
   logic [APP_DATA_WIDTH-1:0] mem_rd;
   logic                      exec_rd, exec_wr, exec_pop;

   always_comb begin
      head_cmd   = cq_cmd[cq_rp[PW-1:0]];
      head_line  = cq_line[cq_rp[PW-1:0]];
      head_wdata = wf_data[wf_rp[PW-1:0]];
      head_wmask = wf_mask[wf_rp[PW-1:0]];
      mem_rd     = mem[head_line];
      exec_rd    = 1'b0;
      exec_wr    = 1'b0;
      exec_pop   = 1'b0;
      if (!cq_empty && !refresh) begin
         if (head_cmd == CMD_RD) begin
            exec_rd  = 1'b1;
            exec_pop = 1'b1;
         end else if (head_cmd == CMD_WR) begin
            // A write without its data stalls the whole queue to keep program order.
            if (!wf_empty) begin
               exec_wr  = 1'b1;
               exec_pop = 1'b1;
            end
         end else begin
            exec_pop = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_x) begin
         cq_wp <= '0;
         cq_rp <= '0;
         wf_wp <= '0;
         wf_rp <= '0;
      end else begin
         if (cq_push)  cq_wp <= cq_wp + PTR_ONE;
         if (exec_pop) cq_rp <= cq_rp + PTR_ONE;
         if (wf_push)  wf_wp <= wf_wp + PTR_ONE;
         if (exec_wr)  wf_rp <= wf_rp + PTR_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (cq_push) begin
         cq_cmd[cq_wp[PW-1:0]]  <= i_app_cmd;
         cq_line[cq_wp[PW-1:0]] <= i_app_addr[3 +: LW];
      end
      if (wf_push) begin
         wf_data[wf_wp[PW-1:0]] <= i_app_wdf_data;
         wf_mask[wf_wp[PW-1:0]] <= i_app_wdf_mask;
      end
   end

   // Array contents deliberately survive reset.
   always_ff @(posedge i_clk) begin
      if (exec_wr) begin
         for (int b = 0; b < APP_MASK_WIDTH; b++) begin
            if (!head_wmask[b]) mem[head_line][b*8 +: 8] <= head_wdata[b*8 +: 8];
         end
      end
   end

   logic [RD_LATENCY-1:0]     pv;
   logic [APP_DATA_WIDTH-1:0] pd [RD_LATENCY];

   // Data stages load only with a valid beat, so the last stage holds between reads.
   always_ff @(posedge i_clk) begin
      if (!i_rst_x) begin
         pv <= '0;
         for (int i = 0; i < RD_LATENCY; i++) pd[i] <= '0;
      end else begin
         pv[0] <= exec_rd;
         if (exec_rd) pd[0] <= mem_rd;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pv[i] <= pv[i-1];
            if (pv[i-1]) pd[i] <= pd[i-1];
         end
      end
   end

   assign o_app_rd_data       = pd[RD_LATENCY-1];
   assign o_app_rd_data_valid = pv[RD_LATENCY-1];
   assign o_app_rd_data_end   = pv[RD_LATENCY-1];

   logic unused_bits;
   assign unused_bits = ^{i_app_wdf_end, i_app_addr[2:0], i_app_addr[APP_ADDR_WIDTH-1:3+LW]};

endmodule

// File: tb/tb_dram_app_model.sv
// Randomised bench for dram_app_model against a queue-based behavioural model.
module tb_dram_app_model;

   localparam int LAT  = 8;
   localparam int QD   = 4;
   localparam int INIT = 16;
   localparam logic [2:0] WR = 3'd0;
   localparam logic [2:0] RD = 3'd1;

   logic         clk = 1'b0;
   logic         rst_x = 1'b0;
   logic         calib;
   logic [27:0]  app_addr = '0;
   logic [2:0]   app_cmd = '0;
   logic         app_en = 1'b0;
   logic         app_rdy;
   logic [127:0] wdf_data = '0;
   logic [15:0]  wdf_mask = '0;
   logic         wdf_wren = 1'b0;
   logic         wdf_rdy;
   logic [127:0] rd_data;
   logic         rd_valid;
   logic         rd_end;

   always #5 clk = ~clk;

   dram_app_model dut (
      .i_clk                 (clk),
      .i_rst_x               (rst_x),
      .o_init_calib_complete (calib),
      .i_app_addr            (app_addr),
      .i_app_cmd             (app_cmd),
      .i_app_en              (app_en),
      .o_app_rdy             (app_rdy),
      .i_app_wdf_data        (wdf_data),
      .i_app_wdf_mask        (wdf_mask),
      .i_app_wdf_wren        (wdf_wren),
      .i_app_wdf_end         (1'b1),
      .o_app_wdf_rdy         (wdf_rdy),
      .o_app_rd_data         (rd_data),
      .o_app_rd_data_valid   (rd_valid),
      .o_app_rd_data_end     (rd_end)
   );

   typedef struct { logic [2:0] cmd; int line; } cmd_t;
   typedef struct { logic [127:0] data; logic [15:0] mask; } wd_t;
   typedef struct { longint due; logic [127:0] data; } rd_t;

   cmd_t         cq[$];
   wd_t          wq[$];
   rd_t          pend[$];
   logic [127:0] mm [int];
   logic [127:0] exp_data = '0;
   longint       cyc = 0;
   int           since_rel = 0;
   logic [127:0] seen_data = '0;
   longint       vcyc[$];
   logic         obs_rdy;
   logic [127:0] pre [32];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int line_of(input logic [27:0] a);
      return int'((a >> 3) % 4096);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock cycle: drive inputs, check outputs, advance the reference model.
   task automatic cycle(input logic en, input logic [2:0] cmd, input logic [27:0] addr,
                        input logic wren, input logic [127:0] wd, input logic [15:0] wm,
                        output logic acc, output logic wacc);
      logic m_calib, m_ref, m_rdy, m_wrdy, exp_v;
      cmd_t h;
      wd_t w;
      logic [127:0] ln;
      @(negedge clk);
      app_en = en; app_cmd = cmd; app_addr = addr;
      wdf_wren = wren; wdf_data = wd; wdf_mask = wm;
      m_calib = (since_rel >= INIT);
`ifdef DRAM_REFRESH_EN
      m_ref = m_calib && (((since_rel - INIT) % 512) >= 504);
`else
      m_ref = 1'b0;
`endif
      m_rdy  = m_calib && (cq.size() < QD) && !m_ref;
      m_wrdy = m_calib && (wq.size() < QD);
      exp_v  = (pend.size() > 0) && (pend[0].due == cyc);
      if (exp_v) begin
         exp_data = pend[0].data;
         void'(pend.pop_front());
      end
      check_val("calib", calib, m_calib);
      check_val("app_rdy", app_rdy, m_rdy);
      check_val("wdf_rdy", wdf_rdy, m_wrdy);
      check_val("rd_valid", rd_valid, exp_v);
      check_val("rd_end", rd_end, exp_v);
      check_val("rd_data", rd_data, exp_data);
      obs_rdy = app_rdy;
      if (rd_valid) begin
         seen_data = rd_data;
         vcyc.push_back(cyc);
      end
      if (!m_ref && cq.size() > 0) begin
         h = cq[0];
         if (h.cmd == RD) begin
            void'(cq.pop_front());
            pend.push_back('{due: cyc + LAT, data: (mm.exists(h.line) ? mm[h.line] : '0)});
         end else if (h.cmd == WR) begin
            if (wq.size() > 0) begin
               void'(cq.pop_front());
               w = wq.pop_front();
               ln = mm.exists(h.line) ? mm[h.line] : '0;
               for (int b = 0; b < 16; b++)
                  if (!w.mask[b]) ln[b*8 +: 8] = w.data[b*8 +: 8];
               mm[h.line] = ln;
            end
         end else begin
            void'(cq.pop_front());
         end
      end
      acc  = en && m_rdy;
      wacc = wren && m_wrdy;
      if (acc) cq.push_back('{cmd: cmd, line: line_of(addr)});
      if (wacc) wq.push_back('{data: wd, mask: wm});
      cyc++;
      since_rel++;
   endtask

   task automatic idle(input int n);
      logic a, w;
      for (int i = 0; i < n; i++) cycle(1'b0, WR, '0, 1'b0, '0, '0, a, w);
   endtask

   task automatic xfer(input logic do_cmd, input logic [2:0] cmd, input logic [27:0] addr,
                       input logic do_wd, input logic [127:0] wd, input logic [15:0] wm,
                       output longint acc_cyc);
      logic cdone, wdone, a, w;
      longint t;
      int n;
      cdone = !do_cmd; wdone = !do_wd; n = 0; acc_cyc = -1;
      while (!(cdone && wdone) && n < 50) begin
         t = cyc;
         cycle(!cdone, cmd, addr, !wdone, wd, wm, a, w);
         if (a) begin
            cdone = 1'b1;
            acc_cyc = t;
         end
         if (w) wdone = 1'b1;
         n++;
      end
      check_val("xfer_done", cdone && wdone, 1'b1);
   endtask

   task automatic wait_valids(input int n);
      int k = 0;
      while (vcyc.size() < n && k < 40) begin
         idle(1);
         k++;
      end
      check_val("valid_count", vcyc.size(), n);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_x = 1'b0; app_en = 1'b0; wdf_wren = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_calib", calib, 1'b0);
      check_val("rst_rdy", app_rdy, 1'b0);
      check_val("rst_wdf_rdy", wdf_rdy, 1'b0);
      check_val("rst_valid", rd_valid, 1'b0);
      check_val("rst_data", rd_data, '0);
      rst_x = 1'b1;
      cq.delete(); wq.delete(); pend.delete();
      exp_data = '0;
      since_rel = 1;
      cyc += 5;
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      longint t;
      logic a, w;
      logic [127:0] d1, d2, d3;
      logic [27:0] addr;
      logic [2:0] cmd;
      int r;

      do_reset();
      idle(INIT + 4);

      for (int l = 0; l < 32; l++) begin
         pre[l] = rnd128();
         xfer(1'b1, WR, 28'(l << 3), 1'b1, pre[l], '0, t);
      end

      // Write then read back, checking the fixed latency.
      d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
      vcyc.delete();
      xfer(1'b1, WR, 28'h40, 1'b1, d1, '0, t);
      xfer(1'b1, RD, 28'h40, 1'b0, '0, '0, t);
      wait_valids(1);
      check_val("rd_latency", 128'(vcyc[0]), 128'(t + 9));
      check_val("rd_data_40", seen_data, d1);

      // Byte mask: only the low four bytes get overwritten.
      vcyc.delete();
      xfer(1'b1, WR, 28'h80, 1'b1, {128{1'b1}}, '0, t);
      xfer(1'b1, WR, 28'h80, 1'b1, '0, 16'hFFF0, t);
      xfer(1'b1, RD, 28'h80, 1'b0, '0, '0, t);
      wait_valids(1);
      check_val("mask_rd", seen_data, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);

      // Command ahead of its data blocks the following read.
      d2 = rnd128();
      vcyc.delete();
      xfer(1'b1, WR, 28'hC5, 1'b0, '0, '0, t);
      xfer(1'b1, RD, 28'hC0, 1'b0, '0, '0, t);
      idle(3);
      check_val("blocked_no_valid", vcyc.size(), 0);
      xfer(1'b0, WR, '0, 1'b1, d2, '0, t);
      wait_valids(1);
      check_val("late_data_rd", seen_data, d2);

      // Fill the queue behind a data-less write.
      d3 = rnd128();
      xfer(1'b1, WR, 28'h100, 1'b0, '0, '0, t);
      for (int i = 0; i < 3; i++) cycle(1'b1, RD, 28'h100, 1'b0, '0, '0, a, w);
      cycle(1'b1, RD, 28'h100, 1'b0, '0, '0, a, w);
      check_val("full_rdy_low", obs_rdy, 1'b0);
      vcyc.delete();
      xfer(1'b0, WR, '0, 1'b1, d3, '0, t);
      xfer(1'b1, RD, 28'h100, 1'b0, '0, '0, t);
      wait_valids(4);
      for (int i = 1; i < 4; i++)
         check_val("contiguous", 128'(vcyc[i] - vcyc[i-1]), 128'(1));
      check_val("full_rd_data", seen_data, d3);

      // Reset with a read in flight: read dropped, memory retained.
      xfer(1'b1, RD, 28'h28, 1'b0, '0, '0, t);
      idle(2);
      vcyc.delete();
      do_reset();
      idle(INIT + 4);
      check_val("dropped_read", vcyc.size(), 0);
      xfer(1'b1, RD, 28'h2B, 1'b0, '0, '0, t);
      wait_valids(1);
      check_val("retained_mem", seen_data, pre[5]);

      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 7));
         cmd = (r < 3) ? WR : (r < 6) ? RD : 3'(r);
         addr = (28'($urandom) & 28'hFFF8000) | 28'($urandom_range(0, 31) << 3)
                | 28'($urandom_range(0, 7));
         cycle(1'($urandom), cmd, addr, 1'($urandom), rnd128(), 16'($urandom), a, w);
      end
      idle(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
